sync_debounce_ctrl: RTL and testbench

- Qualifies an asynchronous level input, e.g. a button, strap or external status pin, before core logic uses it.
- The input passes through an internal SYNC_STAGES-deep shift-register synchronizer.
- A qualification FSM with a programmable stability counter sits behind the synchronizer.
- Outputs are a clean registered level plus single-cycle rise/fall event pulses, for interrupt and event logic in the clk domain.

---
 rtl/sync_debounce_ctrl_if.sv | 23 ++
 rtl/sync_debounce_ctrl.sv | 115 +++++++++++
 tb/tb_sync_debounce_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sync_debounce_ctrl_if.sv
// Signal bundle for sync_debounce_ctrl: raw input and controls toward the
// block, qualified level, event pulses and busy back to the consumer.
interface sync_debounce_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             async_in;
  logic             clr;
  logic [CNT_W-1:0] debounce_len;
  logic             level_out;
  logic             rise_pulse;
  logic             fall_pulse;
  logic             busy;

  modport master (
    output async_in, clr, debounce_len,
    input  level_out, rise_pulse, fall_pulse, busy
  );

  modport slave (
    input  async_in, clr, debounce_len,
    output level_out, rise_pulse, fall_pulse, busy
  );
endinterface

// File: rtl/sync_debounce_ctrl.sv
// Synchronizes an asynchronous level, then requires it to stay stable for
// debounce_len extra samples before committing it with a one-cycle event pulse.
module sync_debounce_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sync_debounce_ctrl_if.slave  bus
);
  typedef enum logic {STABLE = 1'b0, QUAL = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       len_q;
  logic                   load_len;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   busy_q;

  // Synchronizer stage boundary: only the last flop feeds the qualifier.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else if (bus.clr) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.async_in};
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    level_d  = level_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    load_len = 1'b0;
    if (bus.clr) begin
      state_d = STABLE;
      cnt_d   = '0;
      level_d = 1'b0;
    end else begin
      case (state_q)
        STABLE: begin
          if (synced != level_q) begin
            if (bus.debounce_len == '0) begin
              level_d = synced;
              rise_d  = synced;
              fall_d  = ~synced;
            end else begin
              load_len = 1'b1;
              cnt_d    = {{(CNT_W-1){1'b0}}, 1'b1};
              state_d  = QUAL;
            end
          end
        end
        QUAL: begin
          if (synced == level_q) begin
            state_d = STABLE;
            cnt_d   = '0;
          end else if (cnt_q == len_q) begin
            level_d = synced;
            rise_d  = synced;
            fall_d  = ~synced;
            state_d = STABLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = STABLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Qualifier / output register boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= STABLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= (state_d == QUAL);
    end
  end

  // The length is only consulted inside QUAL, so it needs no reset.
  always_ff @(posedge clk) begin
    if (load_len) begin
      len_q <= bus.debounce_len;
    end
  end

  assign bus.level_out  = level_q;
  assign bus.rise_pulse = rise_q;
  assign bus.fall_pulse = fall_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_sync_debounce_ctrl.sv
// Bench for sync_debounce_ctrl: directed timeline steps plus random segments,
// compared against a run-length debounce model for a 16-bit and a 4-bit instance.
module tb_sync_debounce_ctrl;
  localparam int SS = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sync_debounce_ctrl_if #(.CNT_W(16)) bus  ();
  sync_debounce_ctrl_if #(.CNT_W(4))  bus4 ();

  sync_debounce_ctrl #(.SYNC_STAGES(SS), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  sync_debounce_ctrl #(.SYNC_STAGES(SS), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: the FSM sees the input from SS edges ago; a change
  // commits once it has been seen on L+1 consecutive edges, L taken at the run start.
  bit q0[$];
  bit q1[$];
  bit e_lvl[2], e_rise[2], e_fall[2], e_busy[2];
  int m_run[2], m_len[2];

  int edge_n;
  int rise_e, fall_e, busy_cnt, pulse_cnt;
  int rise4_e, rise4_cnt, busy4_cnt;

  task automatic mreset(int i);
    e_lvl[i] = 0; e_rise[i] = 0; e_fall[i] = 0; e_busy[i] = 0;
    m_run[i] = 0; m_len[i] = 0;
    if (i == 0) begin
      q0.delete();
      for (int k = 0; k < SS; k++) q0.push_back(1'b0);
    end else begin
      q1.delete();
      for (int k = 0; k < SS; k++) q1.push_back(1'b0);
    end
  endtask

  task automatic step(int i, bit rn, bit a, bit c, int len);
    bit s;
    if (!rn || c) begin
      mreset(i);
      return;
    end
    e_rise[i] = 0;
    e_fall[i] = 0;
    if (i == 0) begin s = q0.pop_front(); q0.push_back(a); end
    else        begin s = q1.pop_front(); q1.push_back(a); end
    if (s != e_lvl[i]) begin
      if (m_run[i] == 0) m_len[i] = len;
      m_run[i]++;
      if (m_run[i] == m_len[i] + 1) begin
        e_lvl[i]  = s;
        e_rise[i] = s;
        e_fall[i] = !s;
        m_run[i]  = 0;
      end
    end else begin
      m_run[i] = 0;
    end
    e_busy[i] = (m_run[i] != 0);
  endtask

  task automatic cmp(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cmp_all();
    cmp("level",  int'(bus.level_out),   int'(e_lvl[0]));
    cmp("rise",   int'(bus.rise_pulse),  int'(e_rise[0]));
    cmp("fall",   int'(bus.fall_pulse),  int'(e_fall[0]));
    cmp("busy",   int'(bus.busy),        int'(e_busy[0]));
    cmp("level4", int'(bus4.level_out),  int'(e_lvl[1]));
    cmp("rise4",  int'(bus4.rise_pulse), int'(e_rise[1]));
    cmp("fall4",  int'(bus4.fall_pulse), int'(e_fall[1]));
    cmp("busy4",  int'(bus4.busy),       int'(e_busy[1]));
  endtask

  task automatic clear_trk();
    edge_n = 0; rise_e = 0; fall_e = 0; busy_cnt = 0; pulse_cnt = 0;
    rise4_e = 0; rise4_cnt = 0; busy4_cnt = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    step(0, rst_n, bus.async_in,  bus.clr,  int'(bus.debounce_len));
    step(1, rst_n, bus4.async_in, bus4.clr, int'(bus4.debounce_len));
    edge_n++;
    #1;
    cmp_all();
    if (bus.rise_pulse && rise_e == 0) rise_e = edge_n;
    if (bus.fall_pulse && fall_e == 0) fall_e = edge_n;
    if (bus.busy) busy_cnt++;
    if (bus.rise_pulse || bus.fall_pulse) pulse_cnt++;
    if (bus4.rise_pulse && rise4_e == 0) rise4_e = edge_n;
    if (bus4.rise_pulse) rise4_cnt++;
    if (bus4.busy) busy4_cnt++;
  endtask

  task automatic run(int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic set_in(bit a);
    bus.async_in = a; bus4.async_in = a;
  endtask

  task automatic set_clr(bit c);
    bus.clr = c; bus4.clr = c;
  endtask

  task automatic set_len(int l);
    bus.debounce_len = 16'(l); bus4.debounce_len = 4'(l);
  endtask

  task automatic clr_tick();
    set_clr(1'b1); tick(); set_clr(1'b0);
  endtask

  initial begin
    bit a;
    int hold;
    mreset(0);
    mreset(1);
    clear_trk();
    set_clr(1'b0);
    set_len(4);
    set_in(1'b1);

    // Reset held with the input high, then a clean rise with L=4.
    run(3);
    #3 rst_n = 1'b1;
    clear_trk();
    run(10);
    cmp("rise_edge_L4", rise_e, 7);
    cmp("busy_cycles_L4", busy_cnt, 4);
    cmp("rise4_edge_L4", rise4_e, 7);

    set_in(1'b0);
    clear_trk();
    run(10);
    cmp("fall_edge_L4", fall_e, 7);

    // Bounce: high for three cycles only.
    set_len(8);
    clear_trk();
    set_in(1'b1);
    run(3);
    set_in(1'b0);
    run(15);
    cmp("bounce_busy_seen", int'(busy_cnt != 0), 1);
    cmp("bounce_pulses", pulse_cnt, 0);
    cmp("bounce_level", int'(bus.level_out), 0);

    // Zero length commits right after the synchronizer.
    set_len(0);
    clr_tick();
    clear_trk();
    set_in(1'b1);
    run(6);
    cmp("rise_edge_L0", rise_e, 3);
    cmp("busy_cycles_L0", busy_cnt, 0);

    // Length change during qualification is ignored until the next one.
    set_in(1'b0);
    set_len(10);
    clr_tick();
    clear_trk();
    set_in(1'b1);
    run(5);
    set_len(2);
    run(12);
    cmp("rise_edge_L10", rise_e, 13);
    clear_trk();
    set_in(1'b0);
    run(8);
    cmp("fall_edge_L2", fall_e, 5);

    // clr during qualification.
    set_len(6);
    clr_tick();
    clear_trk();
    set_in(1'b1);
    run(5);
    cmp("busy_before_clr", int'(bus.busy), 1);
    clr_tick();
    cmp("busy_after_clr", int'(bus.busy), 0);
    cmp("level_after_clr", int'(bus.level_out), 0);
    cmp("pulses_around_clr", pulse_cnt, 0);

    // Asynchronous reset between edges during qualification.
    run(5);
    cmp("busy_before_rst", int'(bus.busy), 1);
    #2 rst_n = 1'b0;
    #1;
    mreset(0);
    mreset(1);
    cmp_all();
    cmp("busy_async_rst", int'(bus.busy), 0);
    cmp("level_async_rst", int'(bus.level_out), 0);
    tick();
    #2 rst_n = 1'b1;
    clear_trk();
    run(12);
    cmp("rise_after_rst_release", rise_e, 9);
    cmp("pulse_count_release", pulse_cnt, 1);

    // Maximum length on the 4-bit instance.
    set_in(1'b0);
    set_len(15);
    clr_tick();
    clear_trk();
    set_in(1'b1);
    run(25);
    cmp("rise4_edge_L15", rise4_e, 18);
    cmp("rise4_count_L15", rise4_cnt, 1);
    cmp("busy4_cycles_L15", busy4_cnt, 15);
    cmp("rise_edge_L15", rise_e, 18);

    // Random segments of held levels, random lengths and occasional clr.
    a = 1'b1;
    for (int seg = 0; seg < 220; seg++) begin
      a = ~a;
      set_in(a);
      if ($urandom_range(0, 2) == 0) set_len($urandom_range(0, 6));
      hold = $urandom_range(1, 12);
      for (int k = 0; k < hold; k++) begin
        if ($urandom_range(0, 60) == 0) set_clr(1'b1);
        tick();
        set_clr(1'b0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
